// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register pending-write scoreboard with issue stall, busy map,
//            in-flight count and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int MAXPEND = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic       issue_wr,
    input  logic [2:0] issue_dst,
    input  logic       src1_use,
    input  logic       src2_use,
    input  logic [2:0] read1regsel,
    input  logic [2:0] read2regsel,
    input  logic       write,
    input  logic [2:0] writeregsel,
    input  logic       flush,
    output logic       stall,
    output logic [7:0] busy,
    output logic [4:0] inflight,
    output logic       err
);

    localparam logic [1:0] c_max_cnt = 2'(MAXPEND);

    logic [1:0] r_cnt      [8];
    logic [1:0] w_cnt_nxt  [8];
    logic       w_inc      [8];
    logic       w_dec      [8];
    logic       r_err;
    logic       w_err_nxt;
    logic       w_hazard1;
    logic       w_hazard2;
    logic       w_full;
    logic       w_accept;

    // Hazards look only at the registered counts, so a same-cycle writeback
    // never releases a stall.
    always_comb begin
        w_hazard1 = src1_use && (r_cnt[read1regsel] != 2'd0);
        w_hazard2 = src2_use && (r_cnt[read2regsel] != 2'd0);
        w_full    = issue_wr && (r_cnt[issue_dst] == c_max_cnt);
        stall     = issue && (w_hazard1 || w_hazard2 || w_full);
        w_accept  = issue && !stall && !flush;
    end

    always_comb begin
        w_err_nxt = r_err;
        for (int i = 0; i < 8; i++) begin
            w_inc[i]     = w_accept && issue_wr && (issue_dst == 3'(i));
            w_dec[i]     = write && (writeregsel == 3'(i));
            w_cnt_nxt[i] = r_cnt[i];
            if (flush) begin
                w_cnt_nxt[i] = 2'd0;
            end else if (w_inc[i] && !w_dec[i]) begin
                if (r_cnt[i] == c_max_cnt) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 2'd1;
                end
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_cnt[i] == 2'd0) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '{default: 2'd0};
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    always_comb begin
        inflight = 5'd0;
        for (int i = 0; i < 8; i++) begin
            busy[i]  = (r_cnt[i] != 2'd0);
            inflight = inflight + {3'd0, r_cnt[i]};
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// Self-checking bench for reg_scoreboard: per-cycle model comparison plus
// directed scenarios with literal expectations.
module tb_reg_scoreboard;

    localparam int MAXPEND = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue, issue_wr, src1_use, src2_use, write, flush;
    logic [2:0] issue_dst, read1regsel, read2regsel, writeregsel;
    logic       stall, err;
    logic [7:0] busy;
    logic [4:0] inflight;

    int checks = 0;
    int errors = 0;

    int m_cnt [8];
    bit m_err;

    reg_scoreboard #(.MAXPEND(MAXPEND)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_wr(issue_wr),
        .issue_dst(issue_dst), .src1_use(src1_use), .src2_use(src2_use),
        .read1regsel(read1regsel), .read2regsel(read2regsel), .write(write),
        .writeregsel(writeregsel), .flush(flush), .stall(stall), .busy(busy),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit exp_stall();
        bit h1, h2, f;
        h1 = src1_use && (m_cnt[read1regsel] > 0);
        h2 = src2_use && (m_cnt[read2regsel] > 0);
        f  = issue_wr && (m_cnt[issue_dst] == MAXPEND);
        return issue && (h1 || h2 || f);
    endfunction

    // Signed net change per register, before clamping.
    function automatic int raw_next(int i);
        int n;
        bit acc;
        acc = issue && !exp_stall() && !flush;
        n = m_cnt[i];
        if (acc && issue_wr && issue_dst == 3'(i)) n = n + 1;
        if (write && writeregsel == 3'(i)) n = n - 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_cnt[i] <= 0;
            m_err <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 8; i++) m_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (raw_next(i) < 0) begin
                    m_cnt[i] <= 0;
                    m_err    <= 1'b1;
                end else if (raw_next(i) > MAXPEND) begin
                    m_cnt[i] <= MAXPEND;
                    m_err    <= 1'b1;
                end else begin
                    m_cnt[i] <= raw_next(i);
                end
            end
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int sum;
        logic [7:0] eb;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            sum += m_cnt[i];
            eb[i] = (m_cnt[i] != 0);
        end
        check("model_stall", int'(stall), int'(exp_stall()));
        check("model_busy", int'(busy), int'(eb));
        check("model_inflight", int'(inflight), sum);
        check("model_err", int'(err), int'(m_err));
    end

    task automatic drive(bit iss, bit wr, int dst, bit s1, int r1, bit s2, int r2,
                         bit wb, int ws, bit fl);
        issue = iss; issue_wr = wr; issue_dst = 3'(dst);
        src1_use = s1; read1regsel = 3'(r1);
        src2_use = s2; read2regsel = 3'(r2);
        write = wb; writeregsel = 3'(ws); flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_inflight", int'(inflight), 0);
        check("reset_err", int'(err), 0);
        @(negedge clk); #1 rst = 1'b1;
        tick();

        // RAW hazard on r3, released by writeback
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); #1;
        check("raw_stall", int'(stall), 1);
        check("raw_busy", int'(busy), 8'h08);
        check("raw_inflight", int'(inflight), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0); tick();
        check("wb_busy", int'(busy), 0);
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); #1;
        check("wb_stall", int'(stall), 0);
        tick();

        // Saturation at MAXPEND on r5, and no writeback bypass
        repeat (3) begin drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1;
        check("full_stall", int'(stall), 1);
        check("full_inflight", int'(inflight), 3);
        check("full_busy", int'(busy), 8'h20);
        tick();
        drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0); #1;
        check("nobypass_stall", int'(stall), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); tick(); tick();
        check("drain_inflight", int'(inflight), 0);

        // Same-cycle issue and writeback to r2 cancel out
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 2, 0, 0, 0, 0, 1, 2, 0); tick();
        check("net0_busy", int'(busy), 8'h04);
        check("net0_inflight", int'(inflight), 1);
        check("net0_err", int'(err), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0); tick();

        // Flush drops everything including a same-cycle issue
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        check("preflush_inflight", int'(inflight), 4);
        drive(1, 1, 7, 0, 0, 0, 0, 1, 1, 1); tick();
        check("flush_inflight", int'(inflight), 0);
        check("flush_busy", int'(busy), 0);
        check("flush_err", int'(err), 0);
        idle(); tick();

        // Underflow sets sticky err
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); tick();
        check("underflow_err", int'(err), 1);
        idle(); repeat (3) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        check("sticky_err", int'(err), 1);

        // Mixed traffic against the model
        for (int k = 0; k < 60; k++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  ($urandom_range(0, 15) == 0));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();

        // Asynchronous reset mid-cycle
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        idle();
        check("prerst_inflight", int'(inflight), 2);
        check("prerst_busy", int'(busy), 8'h10);
        #2 rst = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_inflight", int'(inflight), 0);
        check("async_err", int'(err), 0);
        @(negedge clk); #1 rst = 1'b1;
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); tick();
        check("postrst_inflight", int'(inflight), 1);
        check("postrst_busy", int'(busy), 8'h10);
        idle(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter MAXPEND, default 3, meaning the maximum in-flight writes tracked per register (1..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port issue, input, 1, decode requests to issue an instruction this cycle.
REQ-005 SHALL have port issue_wr, input, 1, the issuing instruction writes a register.
REQ-006 SHALL have port issue_dst, input, 3, destination register of the issuing instruction.
REQ-007 SHALL have port src1_use and src2_use, input, 1 each, the instruction reads the corresponding source.
REQ-008 SHALL have port read1regsel and read2regsel, input, 3 each, source registers (same encoding as the register file read selects).
REQ-009 SHALL have port write, input, 1, writeback commits a register-file write this cycle.
REQ-010 SHALL have port writeregsel, input, 3, register being written back.
REQ-011 SHALL have port flush, input, 1, synchronous clear of all pending state.
REQ-012 SHALL have port stall, output, 1, issue is blocked this cycle.
REQ-013 SHALL have port busy, output, 8, busy[i] high when register i has a nonzero pending count.
REQ-014 SHALL have port inflight, output, 5, total pending writes across all registers.
REQ-015 SHALL have port err, output, 1, sticky error flag.

Function
REQ-016 SHALL hold one 2-bit pending counter per register, cnt[0..7].
REQ-017 SHALL drive stall combinationally = issue AND (hazard1 OR hazard2 OR full), where hazardN = srcN_use AND cnt[readNregsel]!=0 and full = issue_wr AND cnt[issue_dst]==MAXPEND.
REQ-018 SHALL define accept = issue AND NOT stall AND NOT flush.
REQ-019 SHALL on accept with issue_wr increment cnt[issue_dst] at the next edge.
REQ-020 SHALL on write decrement cnt[writeregsel] at the next edge when it is nonzero.
REQ-021 SHALL leave cnt unchanged when accept-with-write and write target the same register in the same cycle (net zero).
REQ-022 SHALL NOT let a same-cycle writeback clear a hazard: stall uses current-cycle cnt only (no bypass).
REQ-023 SHALL set err on write to a register whose cnt is 0 (underflow); counter stays 0.
REQ-024 SHALL set err if an increment would exceed MAXPEND (only reachable via the REQ-021 exception absent); counter saturates.
REQ-025 SHALL on flush set all cnt to 0 at the next edge, ignoring same-cycle issue and write; err unaffected.
REQ-026 SHALL drive busy and inflight combinationally from current cnt; inflight = sum of all cnt.
REQ-027 SHALL keep err high until reset once set.

Reset
REQ-028 SHALL on rst low immediately clear all cnt, err=0, busy=8'h00, inflight=0, independent of clk.
REQ-029 SHALL on rst low mid-operation discard all pending state; first edge after rst high behaves as from empty.

Verification
REQ-030 Reset, issue(wr,dst=3), next cycle issue src1=3 -> busy=8'h08, inflight=1, stall=1; write reg3 -> busy=0, stall=0 next cycle.
REQ-031 Three issues to dst=5 (MAXPEND=3) then fourth -> cnt5=3, fourth cycle stall=1, inflight=3.
REQ-032 cnt2=1, same-cycle accept dst=2 and write reg2 -> cnt2 stays 1, err=0.
REQ-033 All cnt=0, write reg6 -> err=1 next cycle, persists until rst low.
REQ-034 inflight=4 across regs 1,2, flush with issue dst=7 -> next cycle inflight=0, busy=0, cnt7=0.
REQ-035 rst low between edges with cnt4=2 -> busy, inflight clear immediately, before next clk edge.
